// File: rtl/usart_rx_gen.sv
// Parametrised asynchronous serial receiver: 2-flop synchroniser, mid-bit sampling FSM,
// parity/framing/overrun reporting and a small output FIFO with valid/ready handshake.
module usart_rx_gen #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BIT   = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BIT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [DATA_BIT-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = $clog2(DATA_BIT + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int NW           = $clog2(FIFO_DEPTH + 1);
  localparam int EW           = DATA_BIT + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  logic                rx_meta_reg, rs_reg;
  state_t              state_reg, state_next;
  logic [CW-1:0]       clk_cnt_reg, clk_cnt_next;
  logic [BW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DATA_BIT-1:0] shift_reg, shift_next;
  logic                par_err_reg, par_err_next;
  logic                frm_err_reg, frm_err_next;
  logic                push_reg, push_next;
  logic [EW-1:0]       push_word_reg, push_word_next;
  logic                bit_tick;

  // Synchroniser loads idle level on reset so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rs_reg      <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rs_reg      <= rx_meta_reg;
    end
  end

  assign bit_tick = (clk_cnt_reg == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next     = state_reg;
    clk_cnt_next   = clk_cnt_reg + CW'(1);
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    par_err_next   = par_err_reg;
    frm_err_next   = frm_err_reg;
    push_next      = 1'b0;
    push_word_next = push_word_reg;
    case (state_reg)
      S_IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (!rs_reg) begin
          state_next   = S_START;
          par_err_next = 1'b0;
          frm_err_next = 1'b0;
        end
      end
      S_START: begin
        if (clk_cnt_reg == CW'(HALF_BIT - 1)) begin
          clk_cnt_next = '0;
          state_next   = rs_reg ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          shift_next   = {rs_reg, shift_reg[DATA_BIT-1:1]};
          if (bit_cnt_reg == BW'(DATA_BIT - 1)) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          par_err_next = (PARITY == 1) ? ~(^shift_reg ^ rs_reg) : (^shift_reg ^ rs_reg);
          state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          clk_cnt_next = '0;
          frm_err_next = frm_err_reg | ~rs_reg;
          if (bit_cnt_reg == BW'(STOP_BIT - 1)) begin
            bit_cnt_next   = '0;
            push_next      = 1'b1;
            push_word_next = {par_err_reg, frm_err_reg | ~rs_reg, shift_reg};
            // A high final stop bit returns to IDLE at once so a back-to-back start is caught.
            state_next     = rs_reg ? S_IDLE : S_BREAK;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      S_BREAK: begin
        clk_cnt_next = '0;
        if (rs_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      clk_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      par_err_reg   <= 1'b0;
      frm_err_reg   <= 1'b0;
      push_reg      <= 1'b0;
      push_word_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clk_cnt_reg   <= clk_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      par_err_reg   <= par_err_next;
      frm_err_reg   <= frm_err_next;
      push_reg      <= push_next;
      push_word_reg <= push_word_next;
    end
  end

  // Output FIFO: storage is tiny, so the head is read combinationally to be valid with 'valid'.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [NW-1:0] count_reg;
  logic          pop, full, wr_en;
  logic [EW-1:0] head;

  assign valid = (count_reg != '0);
  assign full  = (count_reg == NW'(FIFO_DEPTH));
  assign pop   = valid && ready;
  assign wr_en = push_reg && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_word_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + NW'(1);
        2'b01:   count_reg <= count_reg - NW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign data       = valid ? head[DATA_BIT-1:0] : '0;
  assign frame_err  = valid ? head[DATA_BIT]     : 1'b0;
  assign parity_err = valid ? head[DATA_BIT+1]   : 1'b0;
  assign overrun    = push_reg && full && !pop;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_usart_rx_gen.sv
// Bench for usart_rx_gen: three instances (8N1, 8E1, 8N2) at 16 clocks per bit,
// expected FIFO entries queued at stimulus time and compared as the DUTs pop them.
module tb_usart_rx_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rx;
  logic [2:0] ready;
  logic [2:0] valid, par_err, frm_err, overrun, busy;
  logic [7:0] data [3];

  int checks = 0;
  int failures = 0;
  int pops [3] = '{default: 0};
  int ovr_cnt [3] = '{default: 0};
  logic [9:0] exp_q [3][$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      usart_rx_gen #(
        .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(8),
        .PARITY((gi == 1) ? 2 : 0), .STOP_BIT((gi == 2) ? 2 : 1), .FIFO_DEPTH(4)
      ) u_dut (
        .clk(clk), .reset(reset), .rx(rx[gi]), .data(data[gi]), .valid(valid[gi]),
        .ready(ready[gi]), .parity_err(par_err[gi]), .frame_err(frm_err[gi]),
        .overrun(overrun[gi]), .busy(busy[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One bit time = 16 negedges; entered and left on a negedge.
  task automatic send_frame(input int k, input logic [7:0] d, input bit use_par, input bit pb,
                            input int nstop, input bit s1, input bit s2);
    rx[k] = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[k] = d[i];
      repeat (16) @(negedge clk);
    end
    if (use_par) begin
      rx[k] = pb;
      repeat (16) @(negedge clk);
    end
    rx[k] = s1;
    repeat (16) @(negedge clk);
    if (nstop == 2) begin
      rx[k] = s2;
      repeat (16) @(negedge clk);
    end
    $display("tx k=%0d data=0x%02h par=%0b stop=%0b%0b", k, d, pb, s1, s2);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (overrun[k]) ovr_cnt[k]++;
      if (valid[k] && ready[k]) begin
        pops[k]++;
        check($sformatf("expected_entry_k%0d", k), exp_q[k].size() != 0, 1);
        if (exp_q[k].size() != 0) begin
          logic [9:0] e;
          e = exp_q[k].pop_front();
          check($sformatf("entry_k%0d", k), {par_err[k], frm_err[k], data[k]}, e);
          $display("rx k=%0d data=0x%02h perr=%0b ferr=%0b", k, data[k], par_err[k], frm_err[k]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit seen, held;
    reset = 1'b1;
    rx    = 3'b111;
    ready = 3'b111;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_state_k%0d", k),
            {valid[k], busy[k], overrun[k], par_err[k], frm_err[k], data[k]}, 0);

    // 8N1 0xA5 with latency from the rx falling edge to valid
    exp_q[0].push_back({2'b00, 8'hA5});
    fork
      send_frame(0, 8'hA5, 0, 0, 1, 1, 1);
      begin : lat
        int n;
        n = 0;
        while (!valid[0] && n < 300) begin
          @(posedge clk); #1;
          n++;
        end
        $display("latency cycles=%0d", n);
        check("latency_155pm1", (n >= 154 && n <= 156), 1);
        @(posedge clk); #1;
        check("valid_fall", valid[0], 0);
      end
    join
    repeat (20) @(negedge clk);

    // false start
    p0 = pops[0];
    seen = 0;
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= busy[0];
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_clear", busy[0], 0);
    check("glitch_no_entry", pops[0] - p0, 0);

    // 8E1 parity: wrong then right parity bit
    exp_q[1].push_back({2'b10, 8'h07});
    send_frame(1, 8'h07, 1, 0, 1, 1, 1);
    exp_q[1].push_back({2'b00, 8'h07});
    send_frame(1, 8'h07, 1, 1, 1, 1, 1);
    repeat (20) @(negedge clk);

    // 8N2 with low second stop bit, then a long break
    exp_q[2].push_back({2'b01, 8'h3C});
    send_frame(2, 8'h3C, 0, 0, 2, 1, 0);
    held = 1;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      held &= busy[2];
    end
    check("break_busy_held", held, 1);
    rx[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_clear", busy[2], 0);
    check("break_one_entry", pops[2], 1);

    // overrun: five frames into a depth-4 FIFO with ready low
    @(posedge clk); #2;
    ready[0] = 1'b0;
    @(negedge clk);
    p0 = pops[0];
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q[0].push_back({2'b00, 8'(i)});
      send_frame(0, 8'(i), 0, 0, 1, 1, 1);
    end
    repeat (20) @(negedge clk);
    check("overrun_once", ovr_cnt[0], 1);
    check("full_valid", valid[0], 1);
    @(posedge clk); #2;
    ready[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_pops", pops[0] - p0, 4);
    check("drain_empty", valid[0], 0);
    check("overrun_no_more", ovr_cnt[0], 1);

    // reset during data bit 3 of 0xFF, then a clean 0x5A
    fork
      send_frame(0, 8'hFF, 0, 0, 1, 1, 1);
      begin
        repeat (72) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    p0 = pops[0];
    exp_q[0].push_back({2'b00, 8'h5A});
    send_frame(0, 8'h5A, 0, 0, 1, 1, 1);
    repeat (20) @(negedge clk);
    check("reset_one_entry", pops[0] - p0, 1);

    for (int k = 0; k < 3; k++)
      check($sformatf("queue_drained_k%0d", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
